// File: rtl/bram_scan_decoder_if.sv
// Bus bundle for the BRAM scan decoder: the BRAM read port plus the decoded
// output stream. The decoder takes the master side, the BRAM model and the
// consumer take the slave side.
interface bram_scan_decoder_if #(
  parameter int BRAM_NUMBER_SIZE  = 5,
  parameter int BRAM_ADDRESS_SIZE = 8,
  parameter int I_SIZE            = 0,
  parameter int J_SIZE            = 9,
  parameter int X_SIZE            = 3,
  parameter int DATA_WIDTH        = 8
);
  localparam int I_W = (I_SIZE > 0) ? I_SIZE : 1;

  // BRAM read port
  logic                         rd_en;
  logic [BRAM_NUMBER_SIZE-1:0]  rd_bram_number;
  logic [BRAM_ADDRESS_SIZE-1:0] rd_bram_address;
  logic [DATA_WIDTH-1:0]        rd_data;

  // Decoded output stream
  logic                         out_valid;
  logic                         out_ready;
  logic [I_W-1:0]               out_i;
  logic [J_SIZE-1:0]            out_j;
  logic [X_SIZE-1:0]            out_x_enc;
  logic [DATA_WIDTH-1:0]        out_data;

  modport master (
    output rd_en, rd_bram_number, rd_bram_address,
    input  rd_data,
    output out_valid, out_i, out_j, out_x_enc, out_data,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_bram_number, rd_bram_address,
    output rd_data,
    input  out_valid, out_i, out_j, out_x_enc, out_data,
    output out_ready
  );
endinterface

// File: rtl/bram_scan_decoder.sv
// Sweeps every BRAM location (address inner, bank outer), reads the
// consistent ones and recovers the logical (i, j, x_enc) coordinates by
// inverting the forward address mapping. A credit counter bounds reads in
// flight plus FIFO occupancy so the output FIFO can never overflow.
module bram_scan_decoder #(
  parameter int BRAM_NUMBER_SIZE  = 5,
  parameter int BRAM_ADDRESS_SIZE = 8,
  parameter int I_SIZE            = 0,
  parameter int J_SIZE            = 9,
  parameter int X_SIZE            = 3,
  parameter int DATA_WIDTH        = 8,
  parameter int READ_LATENCY      = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  bram_scan_decoder_if.master   bus
);
  localparam int BN          = BRAM_NUMBER_SIZE;
  localparam int BA          = BRAM_ADDRESS_SIZE;
  localparam int I_W         = (I_SIZE > 0) ? I_SIZE : 1;
  localparam int USED_J_BITS = BA - X_SIZE;
  localparam int NUM_J_BITS  = BN - I_SIZE;
  localparam int OVERLAP     = NUM_J_BITS + USED_J_BITS - J_SIZE;
  localparam int LOC_W       = BN + BA;
  localparam int COORD_W     = I_W + J_SIZE + X_SIZE;
  localparam int ENTRY_W     = COORD_W + DATA_WIDTH;
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  // j bits sourced from the bank number (low) and from the address (high);
  // their intersection is the overlap that must agree for a valid location.
  localparam logic [J_SIZE-1:0] LOW_MASK  = J_SIZE'((64'd1 << NUM_J_BITS) - 64'd1);
  localparam logic [J_SIZE-1:0] HIGH_MASK = ~J_SIZE'((64'd1 << (J_SIZE - USED_J_BITS)) - 64'd1);
  localparam logic [J_SIZE-1:0] OVL_MASK  = LOW_MASK & HIGH_MASK;

  generate
    if (OVERLAP < 0) begin : g_bad_overlap
      $error("bram_scan_decoder: bank/address bits cannot cover the j field");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  // Returns {consistent, i, j, x_enc} for one physical location.
  function automatic logic [COORD_W:0] decode_loc(input logic [BN-1:0] num,
                                                  input logic [BA-1:0] addr);
    logic [J_SIZE-1:0] j_num;
    logic [J_SIZE-1:0] j_addr;
    logic [J_SIZE-1:0] j_val;
    logic [I_W-1:0]    i_val;
    logic              ok;
    j_num  = J_SIZE'(num >> I_SIZE);
    j_addr = J_SIZE'(addr >> X_SIZE) << (J_SIZE - USED_J_BITS);
    ok     = (((j_num ^ j_addr) & OVL_MASK) == '0);
    j_val  = (j_num & LOW_MASK) | (j_addr & ~LOW_MASK);
    i_val  = (I_SIZE > 0) ? I_W'(num) : '0;
    return {ok, i_val, j_val, addr[X_SIZE-1:0]};
  endfunction

  // Circular FIFO pointer increment for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1'b1);
  endfunction

  state_t               state_q;
  logic [LOC_W-1:0]     loc_q;
  logic                 busy_q, done_q, rd_en_q;
  logic [BN-1:0]        rd_num_q;
  logic [BA-1:0]        rd_addr_q;
  logic [COORD_W-1:0]   coord_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [READ_LATENCY-1:0] pv_q;
  logic [COORD_W-1:0]   pc_q [READ_LATENCY];
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic                 valid_q;

  logic [COORD_W:0]     dec_s;
  logic                 issue_s, step_s, push_s, pop_s;

  // Step/issue decisions and next-state credit and FIFO occupancy.
  always_comb begin
    dec_s   = decode_loc(loc_q[LOC_W-1:BA], loc_q[BA-1:0]);
    issue_s = 1'b0;
    step_s  = 1'b0;
    if (state_q == S_SCAN) begin
      // Inconsistent locations advance without a read; consistent ones wait for credit.
      issue_s = dec_s[COORD_W] && (cnt_q < CNT_W'(FIFO_DEPTH));
      step_s  = !dec_s[COORD_W] || (cnt_q < CNT_W'(FIFO_DEPTH));
    end else begin
      issue_s = 1'b0;
      step_s  = 1'b0;
    end
    push_s = pv_q[READ_LATENCY-1];
    pop_s  = valid_q && bus.out_ready;
    case ({issue_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
      default: cnt_d = cnt_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1'b1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1'b1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Scan FSM: location counter, read strobe, credit counter, busy/done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      loc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_num_q  <= '0;
      rd_addr_q <= '0;
      coord_q   <= '0;
      cnt_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= issue_s;
      cnt_q   <= cnt_d;
      if (issue_s) begin
        rd_num_q  <= loc_q[LOC_W-1:BA];
        rd_addr_q <= loc_q[BA-1:0];
        coord_q   <= dec_s[COORD_W-1:0];
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SCAN;
            busy_q  <= 1'b1;
            loc_q   <= '0;
          end
        end
        S_SCAN: begin
          if (step_s) begin
            loc_q <= loc_q + LOC_W'(1'b1);
            if (&loc_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Credit returns to zero only once nothing is in flight or buffered.
          if (cnt_d == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Coordinates ride alongside each read until its data returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pc_q[k] <= '0;
    end else begin
      pv_q[0] <= rd_en_q;
      pc_q[0] <= coord_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pc_q[k] <= pc_q[k-1];
      end
    end
  end

  // Output FIFO: push returning words with their coordinates, pop on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      valid_q  <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {pc_q[READ_LATENCY-1], bus.rd_data};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fcnt_q  <= fcnt_d;
      valid_q <= (fcnt_d != '0);
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign bus.rd_en           = rd_en_q;
  assign bus.rd_bram_number  = rd_num_q;
  assign bus.rd_bram_address = rd_addr_q;
  assign bus.out_valid       = valid_q;
  assign {bus.out_i, bus.out_j, bus.out_x_enc, bus.out_data} = mem_q[rd_ptr_q];
endmodule
